reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- General-purpose register file for the MIPS single-cycle datapath: 32 registers, each DATA_W wide.
- Sits directly downstream of the register-destination select. It consumes that block's 5-bit write address rw, the write-back bus busW and the control signal RegWr.
- Supplies operand buses busA and busB to the ALU and store-data path, plus a debug read port for the bench.

Parameters:
- DATA_W, 32, register and bus width in bits.
- ADDR_W, 5, register address width; register count = 2**ADDR_W.
- BYPASS, 1, when 1, a same-cycle write to a register being read is forwarded to the read bus (write-through). When 0, the read returns the stored value until the clock edge.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- ra  input  ADDR_W  read address, port A (instruction rs field).
- rb  input  ADDR_W  read address, port B (instruction rt field).
- rw  input  ADDR_W  write address, from the register-destination select.
- RegWr  input  1  write enable.
- busW  input  DATA_W  write data, from the write-back select.
- busA  output  DATA_W  read data, port A.
- busB  output  DATA_W  read data, port B.
- dbg_addr  input  ADDR_W  debug read address.
- dbg_data  output  DATA_W  debug read data; never bypassed.

Interface decision: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Storage: 2**ADDR_W registers of DATA_W bits; register 0 is architecturally $zero.
- Reset:
  - On a rising clk edge with rst=1, all registers are cleared to 0.
  - A write presented in the same cycle is discarded; rst has priority over RegWr.
  - From the cycle after reset, busA, busB and dbg_data all read 0 for every address.
  - Reset asserted mid-program clears all state at the next edge, with no partial writes.
- Write:
  - On a rising clk edge with rst=0, RegWr=1 and rw!=0, reg[rw] <= busW.
  - Writes to rw=0 are silently dropped; reg[0] remains 0 at all times.
  - RegWr=0 means no state change, regardless of rw or busW.
- Read:
  - Combinational, asynchronous, with zero cycles of latency: busA = reg[ra], busB = reg[rb], dbg_data = reg[dbg_addr].
  - Address 0 always returns 0. This is enforced at the read mux as well as by the write guard.
- Bypass (BYPASS=1):
  - If RegWr=1, rst=0, rw!=0 and rw==ra, then busA = busW in the same cycle. busB follows the same rule with rw==rb.
  - ra==rb==rw gives both ports busW.
  - No bypass while rst=1.
- BYPASS=0: a read of the register being written returns the pre-edge value; the new value is visible from the cycle after the edge.
- Simultaneous events:
  - Two read ports at the same address return identical data.
  - One write per cycle only; there is no write-port contention by construction.
- No X-propagation:
  - Every register holds a defined value after the first reset.
  - Read muxes must fully decode all 2**ADDR_W addresses; no latch inference.

Decomposition:
- Shared package mips_pkg:
  - DATA_W and ADDR_W defaults.
  - Register index constants REG_ZERO=0, REG_AT=1, REG_SP=29, REG_RA=31 (REG_RA is used later by the jal path).
- One natural sub-module, reg_file_rdport:
  - Address-to-data read mux with the zero-register guard and an optional bypass input.
  - Instantiated three times: A and B with bypass, debug without.
- The storage array and write logic stay in reg_file.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then assert rst for 1 cycle -> busA with ra=5 reads 0x00000000; dbg_data reads 0 for all 32 addresses.
- Write/read: RegWr=1, rw=8, busW=0x12345678, one edge -> ra=8 gives busA=0x12345678 and rb=8 gives busB=0x12345678; r9 is unchanged at 0.
- Zero register: RegWr=1, rw=0, busW=0xFFFFFFFF, one edge -> busA with ra=0 reads 0; this holds with BYPASS=1 while the write is being presented.
- Bypass: BYPASS=1, r3=0x11, then RegWr=1, rw=3, busW=0x22, ra=3, before the edge -> busA=0x22 and dbg_data (addr 3)=0x11. With BYPASS=0, busA=0x11 until the edge and 0x22 after it.
- Reset priority: rst=1 and RegWr=1, rw=7, busW=0xA5A5A5A5 in the same cycle -> after the edge r7=0; during that cycle busA with ra=7 shows no bypass.
- Sweep: write busW=index*0x01010101 to r1..r31 over 31 cycles with RegWr toggling off every 4th cycle -> dbg_data matches the reference model for all addresses; skipped addresses still read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS single-cycle datapath: default widths and
// architectural register indices.
package mips_pkg;

    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_AT   = 5'd1;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_rdport.sv
// One register-file read port: full address decode, $zero guard, and an
// optional forwarded value that overrides the stored register.
module reg_file_rdport
    import mips_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int ADDR_W = MIPS_ADDR_W
) (
    input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              byp_en_i,
    input  logic [DATA_W-1:0] byp_data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_s;

    // Address 0 wins over the forward so $zero can never leak a written value.
    always_comb begin
        data_s = {DATA_W{1'b0}};
        if (addr_i == {ADDR_W{1'b0}}) begin
            data_s = {DATA_W{1'b0}};
        end else if (byp_en_i) begin
            data_s = byp_data_i;
        end else begin
            data_s = regs_i[addr_i];
        end
    end

    assign data_o = data_s;

endmodule

// File: rtl/reg_file.sv
// 32-entry MIPS register file: one write port, two operand read ports with
// optional write-through forwarding, and an unforwarded debug read port.
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int ADDR_W = MIPS_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] rw,
    input  logic              RegWr,
    input  logic [DATA_W-1:0] busW,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              wr_en_s;
    logic              fwd_s;
    logic              fwd_a_s;
    logic              fwd_b_s;

    assign wr_en_s = RegWr && (rw != {ADDR_W{1'b0}});
    assign fwd_s   = BYPASS && !rst && wr_en_s;
    assign fwd_a_s = fwd_s && (rw == ra);
    assign fwd_b_s = fwd_s && (rw == rb);

    // Next-state: single write port, $zero pinned to zero.
    always_comb begin
        regs_d = regs_q;
        if (wr_en_s) begin
            regs_d[rw] = busW;
        end else begin
            regs_d = regs_q;
        end
        regs_d[0] = {DATA_W{1'b0}};
    end

    // Storage update; reset discards any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_file_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_a (
        .regs_i     (regs_q),
        .addr_i     (ra),
        .byp_en_i   (fwd_a_s),
        .byp_data_i (busW),
        .data_o     (busA)
    );

    reg_file_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_b (
        .regs_i     (regs_q),
        .addr_i     (rb),
        .byp_en_i   (fwd_b_s),
        .byp_data_i (busW),
        .data_o     (busB)
    );

    reg_file_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_dbg (
        .regs_i     (regs_q),
        .addr_i     (dbg_addr),
        .byp_en_i   (1'b0),
        .byp_data_i ({DATA_W{1'b0}}),
        .data_o     (dbg_data)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: a forwarding and a non-forwarding instance share
// the same stimulus and are compared against hand-computed values.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  ra, rb, rw, dbg_addr;
    logic        RegWr;
    logic [31:0] busW;
    logic [31:0] busA_y, busB_y, dbg_y;
    logic [31:0] busA_n, busB_n, dbg_n;

    int checks;
    int errors;

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst), .ra(ra), .rb(rb), .rw(rw), .RegWr(RegWr),
        .busW(busW), .busA(busA_y), .busB(busB_y),
        .dbg_addr(dbg_addr), .dbg_data(dbg_y)
    );

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_nob (
        .clk(clk), .rst(rst), .ra(ra), .rb(rb), .rw(rw), .RegWr(RegWr),
        .busW(busW), .busA(busA_n), .busB(busB_n),
        .dbg_addr(dbg_addr), .dbg_data(dbg_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wr;
        logic [4:0]  rw;
        logic [31:0] busw;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  dbg;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_a_nob;
        logic [31:0] exp_b_nob;
        logic [31:0] exp_dbg;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [4:0] a_rw,
                                input logic [31:0] d, input logic [4:0] a_ra,
                                input logic [4:0] a_rb, input logic [4:0] a_dbg,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic [31:0] ean, input logic [31:0] ebn,
                                input logic [31:0] ed);
        vec_t v;
        v.rst = r; v.wr = w; v.rw = a_rw; v.busw = d;
        v.ra = a_ra; v.rb = a_rb; v.dbg = a_dbg;
        v.exp_a = ea; v.exp_b = eb; v.exp_a_nob = ean; v.exp_b_nob = ebn;
        v.exp_dbg = ed;
        return v;
    endfunction

    task automatic clock_edge();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] model [32];
    logic [31:0] val;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; RegWr = 1'b0; rw = 5'd0; busW = 32'h0;
        ra = 5'd0; rb = 5'd0; dbg_addr = 5'd0;

        //           rst   wr    rw     busW           ra     rb     dbg    expA           expB           expA_nob       expB_nob       expDbg
        vecs[0]  = mk(1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'd5,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'h0);
        vecs[1]  = mk(1'b1, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        vecs[2]  = mk(1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0);
        vecs[3]  = mk(1'b0, 1'b1, 5'd8,  32'h12345678, 5'd9,  5'd8,  5'd8,  32'h0,        32'h12345678, 32'h0,        32'h0,        32'h0);
        vecs[4]  = mk(1'b0, 1'b0, 5'd8,  32'h0,        5'd8,  5'd8,  5'd9,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h0);
        vecs[5]  = mk(1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd8,  5'd0,  32'h0,        32'h12345678, 32'h0,        32'h12345678, 32'h0);
        vecs[6]  = mk(1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0);
        vecs[7]  = mk(1'b0, 1'b1, 5'd3,  32'h11,       5'd3,  5'd8,  5'd3,  32'h11,       32'h12345678, 32'h0,        32'h12345678, 32'h0);
        vecs[8]  = mk(1'b0, 1'b1, 5'd3,  32'h22,       5'd3,  5'd3,  5'd3,  32'h22,       32'h22,       32'h11,       32'h11,       32'h11);
        vecs[9]  = mk(1'b0, 1'b0, 5'd3,  32'h33,       5'd3,  5'd3,  5'd3,  32'h22,       32'h22,       32'h22,       32'h22,       32'h22);
        vecs[10] = mk(1'b1, 1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd3,  5'd7,  32'h0,        32'h22,       32'h0,        32'h22,       32'h0);
        vecs[11] = mk(1'b0, 1'b0, 5'd0,  32'h0,        5'd7,  5'd3,  5'd8,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0);
        vecs[12] = mk(1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 5'd31, 32'hCAFEF00D, 32'h0,        32'h0,        32'h0,        32'h0);
        vecs[13] = mk(1'b0, 1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);

        // Initial reset, then every address reads zero on every port.
        clock_edge();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i); ra = 5'(i); rb = 5'(i);
            #1;
            chk($sformatf("rst_dbg[%0d]", i), dbg_y, 32'h0);
            chk($sformatf("rst_a[%0d]", i), busA_y, 32'h0);
            chk($sformatf("rst_b_nob[%0d]", i), busB_n, 32'h0);
        end

        // Table: drive, check the pre-edge combinational view, then clock.
        for (int v = 0; v < 14; v++) begin
            rst = vecs[v].rst; RegWr = vecs[v].wr; rw = vecs[v].rw; busW = vecs[v].busw;
            ra = vecs[v].ra; rb = vecs[v].rb; dbg_addr = vecs[v].dbg;
            #1;
            chk($sformatf("v%0d_busA", v), busA_y, vecs[v].exp_a);
            chk($sformatf("v%0d_busB", v), busB_y, vecs[v].exp_b);
            chk($sformatf("v%0d_busA_nob", v), busA_n, vecs[v].exp_a_nob);
            chk($sformatf("v%0d_busB_nob", v), busB_n, vecs[v].exp_b_nob);
            chk($sformatf("v%0d_dbg", v), dbg_y, vecs[v].exp_dbg);
            chk($sformatf("v%0d_dbg_nob", v), dbg_n, vecs[v].exp_dbg);
            clock_edge();
        end

        // Sweep: reset, then write index*0x01010101 to r1..r31, skipping every 4th.
        rst = 1'b1; RegWr = 1'b0;
        clock_edge();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int i = 1; i < 32; i++) begin
            val = 32'(i) * 32'h01010101;
            rw = 5'(i); busW = val;
            RegWr = ((i % 4) != 0);
            if (RegWr) model[i] = val;
            clock_edge();
        end
        RegWr = 1'b0; rw = 5'd0; busW = 32'h0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i); ra = 5'(i); rb = 5'(31 - i);
            #1;
            chk($sformatf("sweep_dbg[%0d]", i), dbg_y, model[i]);
            chk($sformatf("sweep_dbg_nob[%0d]", i), dbg_n, model[i]);
            chk($sformatf("sweep_a[%0d]", i), busA_y, model[i]);
            chk($sformatf("sweep_b[%0d]", 31 - i), busB_y, model[31 - i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
